// File: rtl/axist_h2h_pkg.sv
// axist_h2h_pkg: shared constants and types for the AXI-ST host-to-host loopback model.
// Holds the CSR map, the LFSR seed/taps, the pattern-mode and FSM encodings, and the link-rate codes.
package axist_h2h_pkg;

  // Link-rate codes used by LEADER_MODE / FOLLOWER_MODE.
  localparam int FULL = 1;
  localparam int HALF = 2;

  // CSR map
  localparam logic [31:0] ADDR_TX_CTRL     = 32'h5000_1000;
  localparam logic [31:0] ADDR_RX_STAT     = 32'h5000_1004;
  localparam logic [31:0] ADDR_LINK_STAT   = 32'h5000_1008;
  localparam logic [31:0] ADDR_DLY_X       = 32'h5000_2000;
  localparam logic [31:0] ADDR_DLY_Y       = 32'h5000_2004;
  localparam logic [31:0] ADDR_DLY_Z       = 32'h5000_2008;
  localparam logic [31:0] ADDR_SRESET      = 32'h5000_3000;
  localparam logic [31:0] ADDR_TX_FIRST_LO = 32'h5000_4000;
  localparam logic [31:0] ADDR_TX_FIRST_HI = 32'h5000_4004;
  localparam logic [31:0] ADDR_TX_LAST_LO  = 32'h5000_4100;
  localparam logic [31:0] ADDR_TX_LAST_HI  = 32'h5000_4104;
  localparam logic [31:0] ADDR_RX_FIRST_LO = 32'h5000_4200;
  localparam logic [31:0] ADDR_RX_FIRST_HI = 32'h5000_4204;
  localparam logic [31:0] ADDR_RX_LAST_LO  = 32'h5000_4300;
  localparam logic [31:0] ADDR_RX_LAST_HI  = 32'h5000_4304;

  // Fibonacci LFSR x^64 + x^63 + x^61 + x^60 + 1: feedback from bits 63, 62, 60, 59.
  localparam logic [63:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Pattern mode; any encoding other than PAT_INC selects the LFSR.
  typedef enum logic [1:0] {
    PAT_INC  = 2'b00,
    PAT_LFSR = 2'b01
  } pat_mode_e;

  typedef enum logic { GEN_IDLE = 1'b0, GEN_RUN = 1'b1 } gen_state_e;
  typedef enum logic { RD_IDLE  = 1'b0, RD_WAIT = 1'b1 } rd_state_e;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axist_h2h_patgen.sv
// axist_h2h_patgen: incrementing / LFSR beat generator. Used both as the leader-side
// traffic source and as the follower-side expected-data reference, so both sides stay
// in lock-step as long as they are seeded and advanced on the same beat boundaries.
module axist_h2h_patgen
  import axist_h2h_pkg::*;
(
  input  logic        clk_phy,
  input  logic        rst_phy_n,
  input  logic        seed,
  input  logic        advance,
  input  logic [1:0]  mode,
  output logic [63:0] data
);

  logic [63:0] lfsr_q;
  logic [7:0]  idx_q;

  // Reseed wins over advance; both sequences step together so the mode can be chosen late.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) begin
      lfsr_q <= LFSR_SEED;
      idx_q  <= '0;
    end else if (seed) begin
      lfsr_q <= LFSR_SEED;
      idx_q  <= '0;
    end else if (advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
      idx_q  <= idx_q + 8'd1;
    end
  end

  assign data = (mode == PAT_INC) ? {56'd0, idx_q} : lfsr_q;

endmodule

// File: rtl/axist_h2h_loopback_model.sv
// axist_h2h_loopback_model: single-clock model of an AXI-ST leader->follower AIB link with a
// CSR traffic harness (link-up timers, generator, fixed-latency pipe, checker, beat captures).
// Optional macro AXIST_ERR_INJECT_EN adds the error-inject bit (bit4 of the soft-reset CSR).
module axist_h2h_loopback_model
  import axist_h2h_pkg::*;
#(
  parameter int AXI_CHNL_NUM   = 1,
  parameter int LEADER_MODE    = 2,
  parameter int FOLLOWER_MODE  = 2,
  parameter int DATAWIDTH      = 40,
  parameter int TOTAL_CHNL_NUM = 24
) (
  input  logic        clk_phy,
  input  logic        rst_phy_n,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wrdata,
  input  logic        i_wren,
  input  logic        i_rden,
  output logic [31:0] o_master_readdata,
  output logic        o_master_readdatavalid,
  output logic        o_master_waitreq,
  output logic        tx_online,
  output logic        rx_online,
  output logic        test_done,
  output logic [63:0] o_tb_patdout,
  output logic        o_tb_axist_valid,
  output logic        o_tb_axist_ready
);

  // Unsupported configurations never bring the link to ready.
  localparam bit CFG_OK   = (AXI_CHNL_NUM == 1) && (DATAWIDTH >= 32) && (TOTAL_CHNL_NUM >= 1);
  localparam int LINK_LAT = 2 + ((LEADER_MODE == HALF) ? 1 : 0) + ((FOLLOWER_MODE == HALF) ? 1 : 0);
  localparam int LAST     = LINK_LAT - 1;

  // Handshake: a beat transfers on an edge where o_tb_axist_valid and o_tb_axist_ready are both 1;
  // valid is held with stable data until that happens, and never depends on ready.

  logic [31:0] dly_x, dly_y, dly_z, up_cnt, rd_addr_q, rd_mux;
  logic        soft_rst, align_done, link_ready, start_acc, tx_acc, gen_valid;
  logic [11:2] ctrl_q;
  logic [3:0]  link_stat;
  logic [1:0]  burst_mode;
  logic [7:0]  burst_n_m1, tx_idx, rx_idx;
  logic [63:0] gen_data, ref_data, rx_data, tx_first, tx_last, rx_first, rx_last;
  logic        rx_done, rx_err;
  logic [LINK_LAT-1:0] pipe_v;
  logic [63:0]         pipe_d [LINK_LAT];
  gen_state_e gen_state, gen_next;
  rd_state_e  rd_state, rd_next;
`ifdef AXIST_ERR_INJECT_EN
  logic inj_en, inj_arm;
`endif

  // CSR writes; unmapped addresses fall through untouched.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) begin
      dly_x    <= 32'd12;
      dly_y    <= 32'd32;
      dly_z    <= 32'd6000;
      soft_rst <= 1'b0;
      ctrl_q   <= '0;
`ifdef AXIST_ERR_INJECT_EN
      inj_en   <= 1'b0;
`endif
    end else if (i_wren) begin
      case (i_wr_addr)
        ADDR_DLY_X:   dly_x  <= i_wrdata;
        ADDR_DLY_Y:   dly_y  <= i_wrdata;
        ADDR_DLY_Z:   dly_z  <= i_wrdata;
        ADDR_TX_CTRL: ctrl_q <= i_wrdata[11:2];
        ADDR_SRESET: begin
          soft_rst <= i_wrdata[0];
`ifdef AXIST_ERR_INJECT_EN
          inj_en   <= i_wrdata[4];
`endif
        end
        default: ;
      endcase
    end
  end

  // Link-up timer: held at zero during soft reset, otherwise counts up and saturates.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) begin
      up_cnt     <= '0;
      link_stat  <= '0;
      align_done <= 1'b0;
    end else if (soft_rst) begin
      up_cnt     <= '0;
      link_stat  <= '0;
      align_done <= 1'b0;
    end else begin
      if (up_cnt != '1) up_cnt <= up_cnt + 32'd1;
      link_stat  <= {up_cnt >= dly_y, up_cnt >= dly_x, up_cnt >= dly_y, up_cnt >= dly_x};
      align_done <= up_cnt >= dly_z;
    end
  end

  assign link_ready = CFG_OK && (link_stat == 4'hF) && align_done;
  assign start_acc  = i_wren && (i_wr_addr == ADDR_TX_CTRL) && i_wrdata[0] && link_ready &&
                      (gen_state == GEN_IDLE) && !soft_rst;
  assign tx_acc     = gen_valid && link_ready;

  // Generator FSM: state register.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n)    gen_state <= GEN_IDLE;
    else if (soft_rst) gen_state <= GEN_IDLE;
    else               gen_state <= gen_next;
  end

  // Generator FSM: run from an accepted start until the last beat transfers.
  always_comb begin
    gen_next = gen_state;
    case (gen_state)
      GEN_IDLE: if (start_acc) gen_next = GEN_RUN;
      GEN_RUN:  if (tx_acc && (tx_idx == burst_n_m1)) gen_next = GEN_IDLE;
      default:  gen_next = GEN_IDLE;
    endcase
  end

  // Generator FSM: valid drops in the same cycle soft reset is raised.
  always_comb begin
    gen_valid = (gen_state == GEN_RUN) && !soft_rst;
  end

  // Burst parameters, leader beat index and leader-side captures.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) begin
      burst_mode <= '0;
      burst_n_m1 <= '0;
      tx_idx     <= '0;
      tx_first   <= '0;
      tx_last    <= '0;
`ifdef AXIST_ERR_INJECT_EN
      inj_arm    <= 1'b0;
`endif
    end else if (soft_rst) begin
      tx_idx   <= '0;
      tx_first <= '0;
      tx_last  <= '0;
    end else if (start_acc) begin
      burst_mode <= i_wrdata[3:2];
      burst_n_m1 <= i_wrdata[11:4];
      tx_idx     <= '0;
      tx_first   <= '0;
      tx_last    <= '0;
`ifdef AXIST_ERR_INJECT_EN
      inj_arm    <= inj_en;
`endif
    end else if (tx_acc) begin
      tx_idx <= tx_idx + 8'd1;
      if (tx_idx == 8'd0)       tx_first <= gen_data;
      if (tx_idx == burst_n_m1) tx_last  <= gen_data;
    end
  end

  axist_h2h_patgen u_gen (
    .clk_phy   (clk_phy),
    .rst_phy_n (rst_phy_n),
    .seed      (soft_rst || start_acc),
    .advance   (tx_acc),
    .mode      (burst_mode),
    .data      (gen_data)
  );

  // Fixed-latency link pipe; flushed on soft reset and on a new start.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LINK_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v    <= (soft_rst || start_acc) ? '0 : {pipe_v[LINK_LAT-2:0], tx_acc};
      pipe_d[0] <= gen_data;
      for (int i = 1; i < LINK_LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

`ifdef AXIST_ERR_INJECT_EN
  assign rx_data = pipe_d[LAST] ^ {63'd0, inj_arm && (rx_idx == 8'd0)};
`else
  assign rx_data = pipe_d[LAST];
`endif

  axist_h2h_patgen u_ref (
    .clk_phy   (clk_phy),
    .rst_phy_n (rst_phy_n),
    .seed      (soft_rst || start_acc),
    .advance   (pipe_v[LAST]),
    .mode      (burst_mode),
    .data      (ref_data)
  );

  // Follower checker: sticky error, done on beat N-1, follower-side captures.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) begin
      rx_idx <= '0; rx_done <= 1'b0; rx_err <= 1'b0; rx_first <= '0; rx_last <= '0;
    end else if (soft_rst || start_acc) begin
      rx_idx <= '0; rx_done <= 1'b0; rx_err <= 1'b0; rx_first <= '0; rx_last <= '0;
    end else if (pipe_v[LAST]) begin
      rx_idx <= rx_idx + 8'd1;
      if (rx_data != ref_data) rx_err <= 1'b1;
      if (rx_idx == 8'd0) rx_first <= rx_data;
      if (rx_idx == burst_n_m1) begin
        rx_last <= rx_data;
        rx_done <= 1'b1;
      end
    end
  end

  // CSR read data select; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (rd_addr_q)
      ADDR_DLY_X:       rd_mux = dly_x;
      ADDR_DLY_Y:       rd_mux = dly_y;
      ADDR_DLY_Z:       rd_mux = dly_z;
      ADDR_TX_CTRL:     rd_mux = {20'd0, ctrl_q, 2'b00};
      ADDR_RX_STAT:     rd_mux = {28'd0, align_done, 1'b0, rx_done, rx_done && !rx_err};
      ADDR_LINK_STAT:   rd_mux = {28'd0, link_stat};
`ifdef AXIST_ERR_INJECT_EN
      ADDR_SRESET:      rd_mux = {27'd0, inj_en, 3'b000, soft_rst};
`else
      ADDR_SRESET:      rd_mux = {31'd0, soft_rst};
`endif
      ADDR_TX_FIRST_LO: rd_mux = tx_first[31:0];
      ADDR_TX_FIRST_HI: rd_mux = tx_first[63:32];
      ADDR_TX_LAST_LO:  rd_mux = tx_last[31:0];
      ADDR_TX_LAST_HI:  rd_mux = tx_last[63:32];
      ADDR_RX_FIRST_LO: rd_mux = rx_first[31:0];
      ADDR_RX_FIRST_HI: rd_mux = rx_first[63:32];
      ADDR_RX_LAST_LO:  rd_mux = rx_last[31:0];
      ADDR_RX_LAST_HI:  rd_mux = rx_last[63:32];
      default:          rd_mux = '0;
    endcase
  end

  // Read FSM: state register.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) rd_state <= RD_IDLE;
    else            rd_state <= rd_next;
  end

  // Read FSM: one wait cycle per request; a held request re-issues after the data cycle.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (i_rden) rd_next = RD_WAIT;
      RD_WAIT: rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Read FSM: wait request is high for exactly the wait state.
  always_comb begin
    o_master_waitreq = (rd_state == RD_WAIT);
  end

  // Read address capture, data register and one-cycle valid pulse.
  always_ff @(posedge clk_phy or negedge rst_phy_n) begin
    if (!rst_phy_n) begin
      rd_addr_q              <= '0;
      o_master_readdata      <= '0;
      o_master_readdatavalid <= 1'b0;
    end else begin
      if ((rd_state == RD_IDLE) && i_rden) rd_addr_q <= i_wr_addr;
      if (rd_state == RD_WAIT) o_master_readdata <= rd_mux;
      o_master_readdatavalid <= (rd_state == RD_WAIT);
    end
  end

  assign tx_online        = link_stat[0] && link_stat[2];
  assign rx_online        = link_stat[1] && link_stat[3];
  assign test_done        = rx_done;
  assign o_tb_axist_valid = gen_valid;
  assign o_tb_axist_ready = link_ready;
  assign o_tb_patdout     = gen_valid ? gen_data : 64'd0;

endmodule

// File: tb/tb_axist_h2h_loopback_model.sv
// tb_axist_h2h_loopback_model: directed bench for the AXI-ST loopback model.
module tb_axist_h2h_loopback_model;

  logic        clk_phy;
  logic        rst_phy_n;
  logic [31:0] i_wr_addr;
  logic [31:0] i_wrdata;
  logic        i_wren;
  logic        i_rden;
  logic [31:0] o_master_readdata;
  logic        o_master_readdatavalid;
  logic        o_master_waitreq;
  logic        tx_online;
  logic        rx_online;
  logic        test_done;
  logic [63:0] o_tb_patdout;
  logic        o_tb_axist_valid;
  logic        o_tb_axist_ready;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  logic [63:0] obs_q[$];

  axist_h2h_loopback_model dut (
    .clk_phy                (clk_phy),
    .rst_phy_n              (rst_phy_n),
    .i_wr_addr              (i_wr_addr),
    .i_wrdata               (i_wrdata),
    .i_wren                 (i_wren),
    .i_rden                 (i_rden),
    .o_master_readdata      (o_master_readdata),
    .o_master_readdatavalid (o_master_readdatavalid),
    .o_master_waitreq       (o_master_waitreq),
    .tx_online              (tx_online),
    .rx_online              (rx_online),
    .test_done              (test_done),
    .o_tb_patdout           (o_tb_patdout),
    .o_tb_axist_valid       (o_tb_axist_valid),
    .o_tb_axist_ready       (o_tb_axist_ready)
  );

  // clock
  initial clk_phy = 1'b0;
  always #5 clk_phy = ~clk_phy;

  // leader-side beat monitor
  always @(posedge clk_phy) begin
    if (rst_phy_n && o_tb_axist_valid && o_tb_axist_ready) obs_q.push_back(o_tb_patdout);
  end

  // reference Fibonacci LFSR: x^64 + x^63 + x^61 + x^60 + 1
  function automatic logic [63:0] m_lfsr(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  function automatic logic [63:0] m_lfsr_n(input int n);
    logic [63:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = m_lfsr(s);
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_phy);
    #1;
  endtask

  task automatic csr_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk_phy); #1;
    i_wren = 1'b1; i_wr_addr = addr; i_wrdata = data;
    @(posedge clk_phy); #1;
    i_wren = 1'b0;
  endtask

  task automatic csr_read(input string tag, input logic [31:0] addr, output logic [31:0] data);
    bit got;
    got = 1'b0;
    @(posedge clk_phy); #1;
    i_rden = 1'b1; i_wr_addr = addr;
    @(posedge clk_phy); #1;
    i_rden = 1'b0;
    check({tag, "_waitreq"}, {63'd0, o_master_waitreq}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_phy); #1;
      if (o_master_readdatavalid) begin got = 1'b1; break; end
    end
    check({tag, "_rdvalid"}, {63'd0, got}, 64'd1);
    data = o_master_readdata;
    @(posedge clk_phy); #1;
    check({tag, "_rdpulse"}, {62'd0, o_master_readdatavalid, o_master_waitreq}, 64'd0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (test_done) break;
      @(posedge clk_phy); #1;
    end
    check(tag, {63'd0, test_done}, 64'd1);
  endtask

  initial begin
    logic [31:0] rd, rd_hi;
    int base;
    bit saw_valid;

    // reset
    rst_phy_n = 1'b0; i_wr_addr = '0; i_wrdata = '0; i_wren = 1'b0; i_rden = 1'b0;
    tick(3);
    check("rst_outputs", {o_master_readdata, o_master_readdatavalid, o_master_waitreq,
                          tx_online, rx_online, test_done, o_tb_axist_valid, o_tb_axist_ready}, 64'd0);
    check("rst_patdout", o_tb_patdout, 64'd0);
    rst_phy_n = 1'b1;

    // reset values of CSRs
    csr_read("link_after_rst", 32'h5000_1008, rd); check("link_after_rst", {32'd0, rd}, 64'h0);
    csr_read("dly_z_rst", 32'h5000_2008, rd);      check("dly_z_rst", {32'd0, rd}, 64'h1770);
    csr_read("dly_x_rst", 32'h5000_2000, rd);      check("dly_x_rst", {32'd0, rd}, 64'd12);
    csr_read("dly_y_rst", 32'h5000_2004, rd);      check("dly_y_rst", {32'd0, rd}, 64'd32);
    csr_read("unmapped", 32'h5000_0000, rd);       check("unmapped", {32'd0, rd}, 64'd0);

    // soft reset pulse, then link-up sequence
    csr_write(32'h5000_3000, 32'h1);
    tick(20);
    csr_read("link_in_sreset", 32'h5000_1008, rd); check("link_in_sreset", {32'd0, rd}, 64'h0);
    csr_write(32'h5000_3000, 32'h0);
    tick(100);
    csr_read("link_pre_align", 32'h5000_1008, rd); check("link_pre_align", {32'd0, rd}, 64'hF);
    csr_read("rx_pre_align", 32'h5000_1004, rd);   check("rx_pre_align", {32'd0, rd}, 64'h0);
    check("ready_pre_align", {63'd0, o_tb_axist_ready}, 64'd0);
    tick(6000);
    csr_read("link_up", 32'h5000_1008, rd);        check("link_up", {32'd0, rd}, 64'hF);
    csr_read("rx_aligned", 32'h5000_1004, rd);     check("rx_aligned", {32'd0, rd[3]}, 64'd1);
    check("online", {62'd0, tx_online, rx_online}, 64'd3);
    check("ready_up", {63'd0, o_tb_axist_ready}, 64'd1);

    // 256-beat LFSR burst
    base = obs_q.size();
    csr_write(32'h5000_1000, 32'h0000_0FF5);
    check("lfsr_valid", {63'd0, o_tb_axist_valid}, 64'd1);
    check("lfsr_beat0", o_tb_patdout, SEED);
    wait_done("lfsr_done", 1000);
    check("lfsr_beats", 64'(obs_q.size() - base), 64'd256);
    check("lfsr_beat1", obs_q[base+1], m_lfsr(SEED));
    check("lfsr_idle", {63'd0, o_tb_axist_valid}, 64'd0);
    csr_read("lfsr_stat", 32'h5000_1004, rd);      check("lfsr_stat", {32'd0, rd}, 64'hB);
    csr_read("txf_lo", 32'h5000_4000, rd);
    csr_read("txf_hi", 32'h5000_4004, rd_hi);      check("lfsr_tx_first", {rd_hi, rd}, SEED);
    csr_read("rxf_lo", 32'h5000_4200, rd);
    csr_read("rxf_hi", 32'h5000_4204, rd_hi);      check("lfsr_rx_first", {rd_hi, rd}, SEED);
    csr_read("txl_lo", 32'h5000_4100, rd);
    csr_read("txl_hi", 32'h5000_4104, rd_hi);      check("lfsr_tx_last", {rd_hi, rd}, m_lfsr_n(255));
    csr_read("rxl_lo", 32'h5000_4300, rd);
    csr_read("rxl_hi", 32'h5000_4304, rd_hi);      check("lfsr_rx_last", {rd_hi, rd}, m_lfsr_n(255));

    // 4-beat incrementing burst
    base = obs_q.size();
    csr_write(32'h5000_1000, 32'h0000_0031);
    check("inc_done_cleared", {63'd0, test_done}, 64'd0);
    wait_done("inc_done", 200);
    check("inc_beats", 64'(obs_q.size() - base), 64'd4);
    check("inc_beat2", obs_q[base+2], 64'd2);
    csr_read("inc_stat", 32'h5000_1004, rd);       check("inc_stat", {32'd0, rd}, 64'hB);
    csr_read("inc_rxf", 32'h5000_4200, rd);        check("inc_rx_first", {32'd0, rd}, 64'd0);
    csr_read("inc_rxl", 32'h5000_4300, rd);
    csr_read("inc_rxl_hi", 32'h5000_4304, rd_hi);  check("inc_rx_last", {rd_hi, rd}, 64'd3);
    csr_read("inc_txl", 32'h5000_4100, rd);        check("inc_tx_last", {32'd0, rd}, 64'd3);

    // start before align done is ignored
    csr_write(32'h5000_3000, 32'h1);
    tick(5);
    csr_write(32'h5000_3000, 32'h0);
    tick(100);
    csr_write(32'h5000_1000, 32'h0000_0FF5);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_tb_axist_valid) saw_valid = 1'b1;
      tick(1);
    end
    check("early_no_valid", {63'd0, saw_valid}, 64'd0);
    csr_read("early_stat", 32'h5000_1004, rd);     check("early_stat", {62'd0, rd[1:0]}, 64'd0);

    // soft reset in the middle of a burst
    tick(6000);
    check("ready_again", {63'd0, o_tb_axist_ready}, 64'd1);
    csr_write(32'h5000_1000, 32'h0000_0FF5);
    tick(50);
    check("mid_valid", {63'd0, o_tb_axist_valid}, 64'd1);
    csr_write(32'h5000_3000, 32'h1);
    check("sreset_valid_drop", {63'd0, o_tb_axist_valid}, 64'd0);
    csr_read("sr_link", 32'h5000_1008, rd);        check("sr_link", {32'd0, rd}, 64'h0);
    check("sr_done", {63'd0, test_done}, 64'd0);
    csr_read("sr_stat", 32'h5000_1004, rd);        check("sr_stat", {32'd0, rd}, 64'h0);
    csr_read("sr_txf", 32'h5000_4000, rd);         check("sr_tx_first", {32'd0, rd}, 64'h0);
    csr_read("sr_rxf", 32'h5000_4204, rd);         check("sr_rx_first", {32'd0, rd}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axist_h2h_loopback_model.md
Name: axist_h2h_loopback_model

Overview:
- Single-clock behavioural model of an AXI4-Stream leader-to-follower link over AIB, with a CSR-driven traffic test harness.
- Contains link-up timers, a pattern generator on the leader side, a fixed-latency link pipeline, and a follower-side checker.
- Captures first and last transmitted and received beats for CSR readback.
- Serves as the top-level DUT for host-to-host AXI-ST system benches.

Parameters:
- AXI_CHNL_NUM, 1: AXI-ST channel count. Only 1 is supported; tdata is 64*AXI_CHNL_NUM bits.
- LEADER_MODE, 2: 1 = full rate, 2 = half rate. Half rate adds 1 link pipeline stage.
- FOLLOWER_MODE, 2: same encoding as LEADER_MODE, applied to the follower side.
- DATAWIDTH, 40: per-channel AIB width. Informational only; must be at least 32.
- TOTAL_CHNL_NUM, 24: AIB channel count. Informational only.

Ports:
- clk_phy  in  1  sole clock.
- rst_phy_n  in  1  asynchronous, active-low reset.
- i_wr_addr  in  32  CSR address for both writes and reads.
- i_wrdata  in  32  CSR write data.
- i_wren  in  1  write strobe, sampled on the clock edge.
- i_rden  in  1  read request.
- o_master_readdata  out  32  CSR read data.
- o_master_readdatavalid  out  1  1-cycle read-data-valid pulse.
- o_master_waitreq  out  1  read wait request.
- tx_online  out  1  link-status bit0 AND bit2.
- rx_online  out  1  link-status bit1 AND bit3.
- test_done  out  1  checker done.
- o_tb_patdout  out  64  generator tdata.
- o_tb_axist_valid  out  1  generator tvalid.
- o_tb_axist_ready  out  1  link tready.

Behaviour:
- Reset: all outputs, CSRs and counters are 0, except the delay CSRs: X = 12, Y = 32, Z = 6000.
- CSR write: applies on an edge where i_wren = 1. Unmapped addresses are ignored.
- CSR read:
  - On the first edge with i_rden = 1, waitreq rises.
  - On the next cycle, readdata is driven, readdatavalid pulses for 1 cycle, and waitreq falls.
  - A read held high re-issues. Reads have no side effects. Unmapped addresses return 0.
- Register map:
  - 0x5000_2000 / 2004 / 2008: delay X / Y / Z, RW, 32 bits each.
  - 0x5000_3000 bit0: soft reset, RW.
  - 0x5000_1000: TX packet control.
    - bit0 start, self-clearing.
    - bits[3:2] pattern mode: 00 = incrementing, 01 = LFSR, others = LFSR.
    - bits[11:4] = packet count minus 1.
  - 0x5000_1004: RX status, RO.
    - bit0 pass = done AND no mismatch.
    - bit1 done.
    - bit3 align done.
  - 0x5000_1008: link status, RO, bits[3:0].
  - 0x5000_4000 / 4004: TX first beat, low / high word.
  - 0x5000_4100 / 4104: TX last beat.
  - 0x5000_4200 / 4204: RX first beat.
  - 0x5000_4300 / 4304: RX last beat.
- Link-up:
  - While soft reset = 1, the 32-bit up-counter and link status are held at 0.
  - After release, the counter increments and saturates.
  - Status bits [0] and [2] set when count ≥ X.
  - Status bits [1] and [3] set when count ≥ Y.
  - Align done sets when count ≥ Z.
  - Asserting soft reset mid-test clears the generator, checker and captures.
- Ready: o_tb_axist_ready = (link status == 4'hF) AND align done.
- Start:
  - Accepted only when ready = 1 and the generator is idle; otherwise ignored.
  - Acceptance clears done, error and all captures, and reseeds both LFSRs.
  - The generator then emits N = cnt + 1 beats. Valid is held until the last beat is accepted (valid AND ready).
  - Ready dropping mid-burst stalls the generator.
- Patterns:
  - Incrementing: beat i = i, zero-extended to 64 bits.
  - LFSR: Fibonacci, taps x^64 + x^63 + x^61 + x^60 + 1, seed 64'h0123_4567_89AB_CDEF. Advances once per accepted beat; beat 0 is the seed.
- Link: each accepted beat appears at the follower after L = 2 + (LEADER_MODE == 2) + (FOLLOWER_MODE == 2) cycles, with no reordering.
- Checker:
  - Regenerates the expected sequence with an identical generator and compares each received beat.
  - Any mismatch sets a sticky error.
  - Done sets on receipt of beat N-1.
- Captures: beat 0 and beat N-1 are latched on each side.

Optional Feature:
- Macro AXIST_ERR_INJECT_EN. With it, bit4 of 0x5000_3000 is RW error-inject.
  - When the bit is set at start, data bit0 of received beat 0 is inverted before the checker.
  - The test then reads status 0xA with bit0 = 0.
- Without the macro, bit4 reads 0 and no injection logic exists.

Decomposition:
- Package axist_h2h_pkg holds:
  - the CSR address localparams;
  - the LFSR seed and taps;
  - the pattern-mode enum;
  - the full/half mode constants: FULL = 1, HALF = 2.
- One sub-module axist_h2h_patgen (LFSR/incrementing generator) is instantiated twice: generator and checker reference.

Test Plan:
- After reset, read 0x5000_2008 → readdata 0x1770; read 0x5000_1008 → 0x0.
- Pulse soft reset and release, wait 6100 cycles → link status 0xF, RX status bit3 = 1, tx_online = rx_online = 1.
- Write 0x5000_1000 = 0xFF5 → 256 LFSR beats. Expect:
  - RX status reads 0xB.
  - TX first = RX first = 0x0123456789ABCDEF.
  - TX last = RX last.
  - test_done = 1.
- Write 0x5000_1000 = 0x031 (mode 00, 4 beats) → RX first = 0, RX last = 3, status 0xB.
- Write start before align done → no valid asserted, status bits[1:0] = 00.
- Assert soft reset mid-burst → link status 0, done 0, captures cleared, valid drops within 1 cycle.
